// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types, init table and init-value lookup for regfile_mp.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int c_init_entries = 16;

    localparam logic [15:0] c_init_table [c_init_entries] = '{
        16'h0000, 16'hFFFF, 16'h0050, 16'hF033,
        16'hF0FF, 16'h0040, 16'h6666, 16'h00FF,
        16'h8888, 16'h0000, 16'h0000, 16'h0000,
        16'hCCCC, 16'h0002, 16'h0000, 16'h0000
    };

    // Entries beyond the table initialise to zero.
    function automatic logic [15:0] init_entry(input int idx);
        if (idx >= 0 && idx < c_init_entries) begin
            return c_init_table[idx[3:0]];
        end
        return 16'h0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_init_seq
// Purpose  : Walks every address once, emitting INIT(addr) for the array.
// Revision : 1.0
// ============================================================================
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] seq_addr_o,
    output logic [DATA_W-1:0] seq_data_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // A request arriving here is ignored: no restart, no extension.
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q == CLEAR);
    assign seq_addr_o = cnt_q;
    assign seq_data_o = DATA_W'(init_entry(int'(cnt_q)));

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with special-register port and re-init.
// Revision : 1.0
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int SP_IDX = 0,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              wrSp,
    input  logic [DATA_W-1:0] wrDataSp,
    input  logic [ADDR_W-1:0] rdAddrR1,
    input  logic [ADDR_W-1:0] rdAddrR2,
    output logic [DATA_W-1:0] rdDataR1,
    output logic [DATA_W-1:0] rdDataR2,
    output logic [DATA_W-1:0] rdDataSp,
    input  logic              clrReq,
    output logic              busy,
    output logic              wrDrop
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_sp_addr = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_drop_q, wr_drop_d;
    logic              seq_busy;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_data;
    logic              fwd_en;
    logic              main_hits_sp;
    logic              sp_commit;

    regfile_init_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req_i  (clrReq),
        .busy_o     (seq_busy),
        .seq_addr_o (seq_addr),
        .seq_data_o (seq_data)
    );

    assign main_hits_sp = wr && (wrAddr == c_sp_addr);
    assign sp_commit    = wrSp && !main_hits_sp;

    generate
        if (BYPASS == 1) begin : g_bypass
            assign fwd_en = !seq_busy;
        end else begin : g_no_bypass
            assign fwd_en = 1'b0;
        end
    endgenerate

    // Main-port forwarding is tested first so it wins over the special port.
    assign rdDataR1 = (fwd_en && wr   && (wrAddr   == rdAddrR1))  ? wrData   :
                      (fwd_en && wrSp && (rdAddrR1 == c_sp_addr)) ? wrDataSp :
                      mem_q[rdAddrR1];
    assign rdDataR2 = (fwd_en && wr   && (wrAddr   == rdAddrR2))  ? wrData   :
                      (fwd_en && wrSp && (rdAddrR2 == c_sp_addr)) ? wrDataSp :
                      mem_q[rdAddrR2];
    assign rdDataSp = (fwd_en && main_hits_sp) ? wrData   :
                      (fwd_en && wrSp)         ? wrDataSp :
                      mem_q[c_sp_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(init_entry(i));
            end
        end else if (seq_busy) begin
            mem_q[seq_addr] <= seq_data;
        end else begin
            if (wr) begin
                mem_q[wrAddr] <= wrData;
            end
            if (sp_commit) begin
                mem_q[c_sp_addr] <= wrDataSp;
            end
        end
    end

    assign wr_drop_d = seq_busy ? (wr || wrSp) : (wrSp && main_hits_sp);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    assign wrDrop = wr_drop_q;
    assign busy   = seq_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp (bypass and non-bypass builds).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0, wrSp = 1'b0, clrReq = 1'b0;
    logic [3:0]  wrAddr = '0, rdAddrR1 = '0, rdAddrR2 = '0;
    logic [15:0] wrData = '0, wrDataSp = '0;
    logic [15:0] rdDataR1, rdDataR2, rdDataSp;
    logic        busy, wrDrop;
    logic [15:0] nb_rd1, nb_rd2, nb_sp;
    logic        nb_busy, nb_drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .SP_IDX(0), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .wr(wr), .wrAddr(wrAddr), .wrData(wrData),
        .wrSp(wrSp), .wrDataSp(wrDataSp), .rdAddrR1(rdAddrR1), .rdAddrR2(rdAddrR2),
        .rdDataR1(rdDataR1), .rdDataR2(rdDataR2), .rdDataSp(rdDataSp),
        .clrReq(clrReq), .busy(busy), .wrDrop(wrDrop)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .SP_IDX(0), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .wr(wr), .wrAddr(wrAddr), .wrData(wrData),
        .wrSp(wrSp), .wrDataSp(wrDataSp), .rdAddrR1(rdAddrR1), .rdAddrR2(rdAddrR2),
        .rdDataR1(nb_rd1), .rdDataR2(nb_rd2), .rdDataSp(nb_sp),
        .clrReq(clrReq), .busy(nb_busy), .wrDrop(nb_drop)
    );

    logic [15:0] init_exp [16] = '{
        16'h0000, 16'hFFFF, 16'h0050, 16'hF033, 16'hF0FF, 16'h0040, 16'h6666, 16'h00FF,
        16'h8888, 16'h0000, 16'h0000, 16'h0000, 16'hCCCC, 16'h0002, 16'h0000, 16'h0000
    };

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        wsp;
        logic [15:0] wdsp;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] esp;
        logic        edrop;
        logic [15:0] e1nb;
        logic [15:0] espnb;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] e1, e2, esp, e1nb, espnb;
        logic        edrop;
    } exp_t;

    vec_t vecs [9];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wr = 1'b0; wrSp = 1'b0; clrReq = 1'b0;
        wrAddr = '0; wrData = '0; wrDataSp = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_init(input string tag);
        for (int i = 0; i < 8; i++) begin
            rdAddrR1 = 4'(i);
            rdAddrR2 = 4'(i + 8);
            @(negedge clk);
            check($sformatf("%s r1[%0d]", tag, i),     rdDataR1, init_exp[i]);
            check($sformatf("%s r2[%0d]", tag, i + 8), rdDataR2, init_exp[i + 8]);
            check($sformatf("%s nb r1[%0d]", tag, i),  nb_rd1,   init_exp[i]);
            check($sformatf("%s nb r2[%0d]", tag, i + 8), nb_rd2, init_exp[i + 8]);
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   nbusy;
        exp_t e;

        vecs[0] = '{1'b1, 4'd5,  16'h1234, 1'b1, 16'hABCD, 4'd5,  4'd0, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 16'h0040, 16'h0000};
        vecs[1] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 4'd5,  4'd0, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 16'h1234, 16'hABCD};
        vecs[2] = '{1'b1, 4'd0,  16'h1111, 1'b1, 16'h2222, 4'd0,  4'd3, 16'h1111, 16'hF033, 16'h1111, 1'b0, 16'hABCD, 16'hABCD};
        vecs[3] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 4'd0,  4'd5, 16'h1111, 16'h1234, 16'h1111, 1'b1, 16'h1111, 16'h1111};
        vecs[4] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 4'd0,  4'd0, 16'h1111, 16'h1111, 16'h1111, 1'b0, 16'h1111, 16'h1111};
        vecs[5] = '{1'b1, 4'd7,  16'h5A5A, 1'b0, 16'h0000, 4'd7,  4'd8, 16'h5A5A, 16'h8888, 16'h1111, 1'b0, 16'h00FF, 16'h1111};
        vecs[6] = '{1'b0, 4'd0,  16'h0000, 1'b1, 16'hBEEF, 4'd0,  4'd7, 16'hBEEF, 16'h5A5A, 16'hBEEF, 1'b0, 16'h1111, 16'h1111};
        vecs[7] = '{1'b1, 4'd12, 16'h0000, 1'b0, 16'h0000, 4'd12, 4'd13, 16'h0000, 16'h0002, 16'hBEEF, 1'b0, 16'hCCCC, 16'hBEEF};
        vecs[8] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 4'd12, 4'd7, 16'h0000, 16'h5A5A, 16'hBEEF, 1'b0, 16'h0000, 16'hBEEF};

        // Reset and initial contents.
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset busy",   {15'b0, busy},   16'h0000);
        check("reset wrDrop", {15'b0, wrDrop}, 16'h0000);
        check("reset rdDataSp", rdDataSp, 16'h0000);
        next_cycle();
        sweep_init("reset");

        // Table-driven vectors through the scoreboard.
        for (int k = 0; k < 9; k++) begin
            wr = vecs[k].wr;   wrAddr = vecs[k].wa;     wrData = vecs[k].wd;
            wrSp = vecs[k].wsp; wrDataSp = vecs[k].wdsp;
            rdAddrR1 = vecs[k].ra1; rdAddrR2 = vecs[k].ra2;
            sb_q.push_back('{k, vecs[k].e1, vecs[k].e2, vecs[k].esp,
                             vecs[k].e1nb, vecs[k].espnb, vecs[k].edrop});
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("vec%0d rdDataR1", e.idx), rdDataR1, e.e1);
            check($sformatf("vec%0d rdDataR2", e.idx), rdDataR2, e.e2);
            check($sformatf("vec%0d rdDataSp", e.idx), rdDataSp, e.esp);
            check($sformatf("vec%0d wrDrop", e.idx), {15'b0, wrDrop}, {15'b0, e.edrop});
            check($sformatf("vec%0d nb rdDataR1", e.idx), nb_rd1, e.e1nb);
            check($sformatf("vec%0d nb rdDataSp", e.idx), nb_sp, e.espnb);
            check($sformatf("vec%0d nb wrDrop", e.idx), {15'b0, nb_drop}, {15'b0, e.edrop});
            next_cycle();
        end
        idle_inputs();

        // Clear sequence: overwrite entry 1, then re-initialise.
        wr = 1'b1; wrAddr = 4'd1; wrData = 16'h0000;
        next_cycle();
        idle_inputs();
        clrReq = 1'b1;
        rdAddrR1 = 4'd1;
        @(negedge clk);
        check("pre-clear r1[1]", rdDataR1, 16'h0000);
        check("pre-clear busy", {15'b0, busy}, 16'h0000);
        next_cycle();
        clrReq = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 40; c++) begin
            wr = (c == 0);
            wrAddr = 4'd1;
            wrData = 16'h7777;
            clrReq = (c == 5);
            rdAddrR1 = 4'd1;
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (c == 0) check("clear c0 r1[1] no bypass", rdDataR1, 16'h0000);
            if (c == 1) check("clear dropped write wrDrop", {15'b0, wrDrop}, 16'h0001);
            if (c == 2) check("clear c2 r1[1] restored", rdDataR1, 16'hFFFF);
            next_cycle();
        end
        idle_inputs();
        check("clear busy cycles", 16'(nbusy), 16'd16);
        next_cycle();
        sweep_init("after clear");

        // Reset in the middle of a clear, with a simultaneous write.
        wr = 1'b1; wrAddr = 4'd6; wrData = 16'h0000;
        next_cycle();
        idle_inputs();
        clrReq = 1'b1;
        next_cycle();
        clrReq = 1'b0;
        repeat (6) next_cycle();
        rst = 1'b0;
        wr = 1'b1; wrAddr = 4'd2; wrData = 16'hDEAD;
        @(negedge clk);
        check("mid-clear busy before reset", {15'b0, busy}, 16'h0001);
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("post-reset busy", {15'b0, busy}, 16'h0000);
        check("post-reset wrDrop", {15'b0, wrDrop}, 16'h0000);
        next_cycle();
        sweep_init("reset mid-clear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
